// File: rtl/mdr_pkg.sv
// Shared types and constants for the sequential multiply/divide/sqrt engine.
package mdr_pkg;

    localparam int DW     = 16;
    localparam int OP_W   = 2;
    localparam int PERIOD = 10;

    typedef enum logic [OP_W-1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_X  = 3'd1,
        S_LOAD_Y  = 3'd2,
        S_CHECK   = 3'd3,
        S_COMPUTE = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/mdr_unit_ctrl.sv
// Transaction sequencer: operand handshake, error branch and iteration count.
module mdr_unit_ctrl
    import mdr_pkg::*;
#(
    parameter int DW   = mdr_pkg::DW,
    parameter int OP_W = mdr_pkg::OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            load,
    input  logic [OP_W-1:0] op,
    input  logic            err_chk,
    output op_e             op_q,
    output logic            st_start,
    output logic            cap_x,
    output logic            cap_y,
    output logic            chk_err,
    output logic            chk_ok,
    output logic            step,
    output logic            last,
    output logic            load_x,
    output logic            load_y,
    output logic            ready
);

    localparam int CW = $clog2(DW);

    state_e        state_q, state_d;
    op_e           op_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    state_d = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                if (load) begin
                    state_d = (op_q == OP_MUL || op_q == OP_DIV) ? S_LOAD_Y : S_CHECK;
                end
            end
            S_LOAD_Y: begin
                if (load) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (err_chk) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COMPUTE;
                    cnt_d   = (op_q == OP_SQRT) ? CW'(DW/2 - 1) : CW'(DW - 1);
                end
            end
            S_COMPUTE: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign st_start = start && (state_q == S_IDLE || state_q == S_DONE);
    assign cap_x    = load && (state_q == S_LOAD_X);
    assign cap_y    = load && (state_q == S_LOAD_Y);
    assign chk_err  = (state_q == S_CHECK) && err_chk;
    assign chk_ok   = (state_q == S_CHECK) && !err_chk;
    assign step     = (state_q == S_COMPUTE);
    assign last     = (state_q == S_COMPUTE) && (cnt_q == '0);
    assign load_x   = (state_q == S_LOAD_X);
    assign load_y   = (state_q == S_LOAD_Y);
    assign ready    = (state_q == S_DONE);

endmodule

// File: rtl/mdr_unit.sv
// Multiply/divide/sqrt engine top: operand registers and the shared iterative datapath.
module mdr_unit
    import mdr_pkg::*;
#(
    parameter int DW   = mdr_pkg::DW,
    parameter int OP_W = mdr_pkg::OP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [OP_W-1:0]        op,
    input  logic                   load,
    input  logic signed [DW-1:0]   data,
    output logic                   load_x,
    output logic                   load_y,
    output logic signed [2*DW-1:0] result,
    output logic signed [DW-1:0]   remainder,
    output logic                   error,
    output logic                   ready
);

    op_e  op_q;
    logic st_start, cap_x, cap_y, chk_err, chk_ok, step, last, err_chk;

    logic [DW-1:0]   x_q, x_d, y_q, y_d, aux_q, aux_d, rem_q, rem_d;
    logic [2*DW-1:0] acc_q, acc_d, sh_q, sh_d, result_q, result_d;
    logic            error_q, error_d;

    logic [DW-1:0]   mag_x, mag_y, aux_s;
    logic [2*DW-1:0] acc_s, sh_s, quo;
    logic [DW:0]     div_r;
    logic [DW+1:0]   sq_r, sq_t;
    logic            neg;

    mdr_unit_ctrl #(.DW(DW), .OP_W(OP_W)) u_ctrl (
        .clk(clk), .rst(rst), .start(start), .load(load), .op(op),
        .err_chk(err_chk), .op_q(op_q), .st_start(st_start),
        .cap_x(cap_x), .cap_y(cap_y), .chk_err(chk_err), .chk_ok(chk_ok),
        .step(step), .last(last), .load_x(load_x), .load_y(load_y),
        .ready(ready)
    );

    // Iterations run on magnitudes; -2^(DW-1) maps onto an unsigned DW-bit value.
    assign mag_x   = x_q[DW-1] ? (~x_q + DW'(1)) : x_q;
    assign mag_y   = y_q[DW-1] ? (~y_q + DW'(1)) : y_q;
    assign neg     = x_q[DW-1] ^ y_q[DW-1];
    assign err_chk = (op_q == OP_RSV) ||
                     (op_q == OP_DIV && y_q == '0) ||
                     (op_q == OP_SQRT && x_q[DW-1]);

    always_comb begin
        acc_s = acc_q;
        sh_s  = sh_q;
        aux_s = aux_q;
        div_r = '0;
        sq_r  = '0;
        sq_t  = '0;
        unique case (op_q)
            OP_MUL: begin
                acc_s = aux_q[0] ? acc_q + sh_q : acc_q;
                sh_s  = sh_q << 1;
                aux_s = aux_q >> 1;
            end
            OP_DIV: begin
                div_r = {acc_q[DW-1:0], aux_q[DW-1]};
                if (div_r >= {1'b0, mag_y}) begin
                    div_r = div_r - {1'b0, mag_y};
                    sh_s  = {sh_q[2*DW-2:0], 1'b1};
                end else begin
                    sh_s  = {sh_q[2*DW-2:0], 1'b0};
                end
                acc_s = {{(DW-1){1'b0}}, div_r};
                aux_s = aux_q << 1;
            end
            OP_SQRT: begin
                // Bring down two radicand bits; trial subtrahend is 4*root + 1.
                sq_r = {acc_q[DW-1:0], aux_q[DW-1:DW-2]};
                sq_t = {sh_q[DW-1:0], 2'b01};
                if (sq_r >= sq_t) begin
                    sq_r = sq_r - sq_t;
                    sh_s = {sh_q[2*DW-2:0], 1'b1};
                end else begin
                    sh_s = {sh_q[2*DW-2:0], 1'b0};
                end
                acc_s = {{(DW-2){1'b0}}, sq_r};
                aux_s = aux_q << 2;
            end
            default: ;
        endcase
        quo = {{DW{1'b0}}, sh_s[DW-1:0]};
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        aux_d    = aux_q;
        result_d = result_q;
        rem_d    = rem_q;
        error_d  = error_q;
        if (st_start) begin
            result_d = '0;
            rem_d    = '0;
            error_d  = 1'b0;
        end
        if (cap_x) x_d = data;
        if (cap_y) y_d = data;
        if (chk_err) begin
            error_d  = 1'b1;
            result_d = '0;
            rem_d    = '0;
        end
        if (chk_ok) begin
            acc_d = '0;
            unique case (op_q)
                OP_MUL:  begin sh_d = {{DW{1'b0}}, mag_x}; aux_d = mag_y; end
                OP_DIV:  begin sh_d = '0; aux_d = mag_x; end
                default: begin sh_d = '0; aux_d = x_q; end
            endcase
        end
        if (step) begin
            acc_d = acc_s;
            sh_d  = sh_s;
            aux_d = aux_s;
        end
        if (last) begin
            unique case (op_q)
                OP_MUL: begin
                    result_d = neg ? -acc_s : acc_s;
                    rem_d    = '0;
                end
                OP_DIV: begin
                    result_d = neg ? -quo : quo;
                    rem_d    = x_q[DW-1] ? -acc_s[DW-1:0] : acc_s[DW-1:0];
                end
                OP_SQRT: begin
                    result_d = sh_s;
                    rem_d    = acc_s[DW-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            aux_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            aux_q    <= aux_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            error_q  <= error_d;
        end
    end

    assign result    = result_q;
    assign remainder = rem_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Scoreboard bench for mdr_unit: arithmetic, latency, handshake and reset behaviour.
module tb_mdr_unit;
    import mdr_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [15:0] rem;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, load;
    logic [1:0]  op;
    logic [15:0] data;
    logic        load_x, load_y, error, ready;
    logic [31:0] result;
    logic [15:0] remainder;

    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    exp_t sb[$];

    mdr_unit #(.DW(16), .OP_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .load(load),
        .data(data), .load_x(load_x), .load_y(load_y), .result(result),
        .remainder(remainder), .error(error), .ready(ready)
    );

    always #(PERIOD/2) clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] opc, input int x, input int y);
        exp_t   e;
        longint r;
        int     s;
        e.res = '0; e.rem = '0; e.err = 1'b0; e.lat = 1;
        case (opc)
            2'b00: begin
                r = longint'(x) * longint'(y);
                e.res = r[31:0]; e.lat = 17;
            end
            2'b01: begin
                if (y == 0) e.err = 1'b1;
                else begin
                    r = longint'(x) / longint'(y);
                    e.res = r[31:0];
                    r = longint'(x) % longint'(y);
                    e.rem = r[15:0];
                    e.lat = 17;
                end
            end
            2'b10: begin
                if (x < 0) e.err = 1'b1;
                else begin
                    s = 0;
                    while ((s + 1) * (s + 1) <= x) s++;
                    e.res = 32'(s);
                    e.rem = 16'(x - s * s);
                    e.lat = 9;
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [1:0] opc, input int x, input int y,
                          input bit noise, input bit join_load);
        exp_t e;
        int   cap;
        bit   got, saw_y;
        sb.push_back(model(opc, x, y));
        @(negedge clk);
        start = 1'b1; op = opc;
        if (join_load) begin load = 1'b1; data = 16'h0055; end
        @(negedge clk);
        start = 1'b0; load = 1'b0;
        chk_eq("start_clr_ready", ready, 0);
        chk_eq("start_clr_result", result, 0);
        chk_eq("load_x_high", load_x, 1);
        load = 1'b1; data = x[15:0];
        @(negedge clk);
        load = 1'b0; cap = cycle;
        if (opc == 2'b00 || opc == 2'b01) begin
            chk_eq("load_y_high", load_y, 1);
            load = 1'b1; data = y[15:0];
            @(negedge clk);
            load = 1'b0; cap = cycle;
        end
        got = 0; saw_y = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready) begin got = 1; break; end
            if (load_y) saw_y = 1;
            if (noise) begin
                start = (i == 3);
                load  = (i == 4);
                data  = 16'h7FFF;
            end
            @(negedge clk);
        end
        start = 1'b0; load = 1'b0;
        if (opc[1]) chk_eq("no_load_y", saw_y, 0);
        e = sb.pop_front();
        if (!got) begin
            chk_eq("ready_timeout", 0, 1);
        end else begin
            chk_eq("latency", cycle - cap, e.lat);
            chk_eq("result", result, e.res);
            chk_eq("remainder", remainder, e.rem);
            chk_eq("error", error, e.err);
        end
    endtask

    task automatic reset_mid_op();
        bit rdy_seen;
        @(negedge clk); start = 1'b1; op = 2'b00;
        @(negedge clk); start = 1'b0; load = 1'b1; data = 16'd7;
        @(negedge clk); load = 1'b1; data = 16'hFFFD;
        @(negedge clk); load = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_eq("rst_result", result, 0);
        chk_eq("rst_remainder", remainder, 0);
        chk_eq("rst_error", error, 0);
        chk_eq("rst_ready", ready, 0);
        chk_eq("rst_load_x", load_x, 0);
        chk_eq("rst_load_y", load_y, 0);
        rdy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready || result != 0) rdy_seen = 1;
        end
        chk_eq("rst_no_partial", rdy_seen, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load = 1'b0; op = 2'b00; data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_eq("init_result", result, 0);
        chk_eq("init_remainder", remainder, 0);
        chk_eq("init_error", error, 0);
        chk_eq("init_ready", ready, 0);
        chk_eq("init_load_x", load_x, 0);
        chk_eq("init_load_y", load_y, 0);

        // Stray loads while idle must not start anything.
        @(negedge clk); load = 1'b1; data = 16'h1234;
        @(negedge clk); load = 1'b0;
        chk_eq("idle_load_x", load_x, 0);
        chk_eq("idle_ready", ready, 0);

        run_op(2'b00, 7, -3, 0, 0);
        run_op(2'b00, -32768, -32768, 0, 0);
        run_op(2'b00, 0, -5, 0, 0);
        run_op(2'b00, -1, 32767, 0, 0);
        run_op(2'b00, 123, -456, 1, 0);
        run_op(2'b01, 100, 7, 0, 0);
        run_op(2'b01, -100, 7, 0, 0);
        run_op(2'b01, 100, -7, 1, 0);
        run_op(2'b01, -32768, -1, 0, 0);
        run_op(2'b01, -7, 100, 0, 0);
        run_op(2'b01, 5, 0, 0, 0);
        run_op(2'b10, 1000, 0, 0, 0);
        run_op(2'b10, -4, 0, 0, 0);
        run_op(2'b10, 0, 0, 0, 0);
        run_op(2'b10, 32767, 0, 1, 0);
        run_op(2'b10, 1, 0, 0, 0);
        run_op(2'b11, 42, 0, 0, 0);
        run_op(2'b01, 1000, 33, 0, 1);

        reset_mid_op();
        run_op(2'b00, 7, -3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(PERIOD * 50000);
        $display("FAIL global_timeout: got %0d cycles expected completion", cycle);
        $fatal(1, "global timeout");
    end

endmodule
